// File: rtl/ir_nec_pkg.sv
// rtl/ir_nec_pkg.sv - NEC transmitter states, segment unit counts and frame helpers
package ir_nec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_REP_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK
  } nec_state_t;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned REP_SPACE_U  = 4;
  localparam int unsigned BIT_MARK_U   = 1;
  localparam int unsigned ZERO_SPACE_U = 1;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned STOP_U       = 1;
  localparam int unsigned FRAME_BITS   = 32;
  localparam int unsigned SEG_W        = 5;

  // Bit 0 leaves first, so the receiver sees the address in the low byte.
  function automatic logic [31:0] nec_frame_word(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  function automatic logic [SEG_W-1:0] space_units(input logic b);
    return b ? SEG_W'(ONE_SPACE_U) : SEG_W'(ZERO_SPACE_U);
  endfunction

endpackage

// File: rtl/ir_transmit_if.sv
// rtl/ir_transmit_if.sv - request and waveform signals of the NEC transmitter
interface ir_transmit_if;
  logic       iSTART;
  logic       iREPEAT;
  logic [7:0] iADDR;
  logic [7:0] iCMD;
  logic       oIRDA_TX;
  logic       oENV;
  logic       oBUSY;
  logic       oDONE;

  modport master (
    output iSTART, iREPEAT, iADDR, iCMD,
    input  oIRDA_TX, oENV, oBUSY, oDONE
  );

  modport slave (
    input  iSTART, iREPEAT, iADDR, iCMD,
    output oIRDA_TX, oENV, oBUSY, oDONE
  );
endinterface

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - square-wave carrier phase with synchronous restart to high
module ir_carrier_gen #(
  parameter int unsigned HALF = 658
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic phase_d_o
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en) begin
      if (cnt_q == CW'(HALF - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Next phase is exported so the owner can register a glitch-free gated output.
  assign phase_d_o = phase_d;

endmodule

// File: rtl/ir_transmit.sv
// rtl/ir_transmit.sv - NEC frame / repeat-code transmitter with 38 kHz modulated output
module ir_transmit
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES  = 28125,
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  ir_transmit_if.slave bus
);

  localparam int UW = $clog2(UNIT_CYCLES + 1);

  nec_state_t       state_q;
  logic [UW-1:0]    unit_q;
  logic [SEG_W-1:0] seg_q;
  logic [4:0]       bit_idx_q;
  logic [31:0]      word_q;
  logic             rep_q;
  logic             env_q, busy_q, done_q, tx_q;

  logic start_ok, unit_end, step, enter_mark, env_d, phase_d;

  // step marks the last cycle of the current segment; every space is followed by a mark.
  always_comb begin
    start_ok   = (state_q == S_IDLE) && bus.iSTART;
    unit_end   = (unit_q == '0);
    step       = (state_q != S_IDLE) && unit_end && (seg_q == SEG_W'(1));
    enter_mark = start_ok ||
                 (step && (state_q == S_LEAD_SPACE || state_q == S_REP_SPACE ||
                           state_q == S_BIT_SPACE));
    env_d      = enter_mark ? 1'b1 : (step ? 1'b0 : env_q);
  end

  ir_carrier_gen #(
    .HALF (CARRIER_HALF)
  ) u_carrier (
    .clk       (iCLK),
    .rst_n     (iRST_n),
    .en        (env_d),
    .restart   (enter_mark),
    .phase_d_o (phase_d)
  );

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      unit_q    <= '0;
      seg_q     <= '0;
      bit_idx_q <= '0;
      word_q    <= '0;
      rep_q     <= 1'b0;
      env_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= 1'b0;
    end else begin
      env_q  <= env_d;
      tx_q   <= env_d & phase_d;
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (bus.iSTART) begin
          state_q   <= S_LEAD_MARK;
          seg_q     <= SEG_W'(LEAD_MARK_U);
          unit_q    <= UW'(UNIT_CYCLES - 1);
          word_q    <= nec_frame_word(bus.iADDR, bus.iCMD);
          rep_q     <= bus.iREPEAT;
          bit_idx_q <= '0;
          busy_q    <= 1'b1;
        end
      end else if (!unit_end) begin
        unit_q <= unit_q - 1'b1;
      end else begin
        unit_q <= UW'(UNIT_CYCLES - 1);
        if (seg_q != SEG_W'(1)) begin
          seg_q <= seg_q - 1'b1;
        end else begin
          case (state_q)
            S_LEAD_MARK: begin
              state_q <= rep_q ? S_REP_SPACE : S_LEAD_SPACE;
              seg_q   <= rep_q ? SEG_W'(REP_SPACE_U) : SEG_W'(LEAD_SPACE_U);
            end
            S_LEAD_SPACE: begin
              state_q   <= S_BIT_MARK;
              seg_q     <= SEG_W'(BIT_MARK_U);
              bit_idx_q <= '0;
            end
            S_REP_SPACE: begin
              state_q <= S_STOP_MARK;
              seg_q   <= SEG_W'(STOP_U);
            end
            S_BIT_MARK: begin
              state_q <= S_BIT_SPACE;
              seg_q   <= space_units(word_q[bit_idx_q]);
            end
            S_BIT_SPACE: begin
              if (bit_idx_q == 5'(FRAME_BITS - 1)) begin
                state_q <= S_STOP_MARK;
                seg_q   <= SEG_W'(STOP_U);
              end else begin
                state_q   <= S_BIT_MARK;
                seg_q     <= SEG_W'(BIT_MARK_U);
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
            S_STOP_MARK: begin
              state_q   <= S_IDLE;
              unit_q    <= '0;
              seg_q     <= '0;
              bit_idx_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end
            default: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.oIRDA_TX = tx_q;
  assign bus.oENV     = env_q;
  assign bus.oBUSY    = busy_q;
  assign bus.oDONE    = done_q;

endmodule

// File: tb/tb_ir_transmit.sv
// tb/tb_ir_transmit.sv - self-checking bench for ir_transmit against a segment-list waveform model
module tb_ir_transmit;

  localparam int U  = 10;
  localparam int CH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_transmit_if bus();

  ir_transmit #(
    .UNIT_CYCLES  (U),
    .CARRIER_HALF (CH)
  ) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  cmd;
    bit          rep;
    int          pulse_at;
    bit          hold;
    int          exp_busy;
    logic [31:0] exp_word;
    int          exp_space;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  bit   exp_env[$];
  bit   exp_tx[$];
  bit   act_env[$];
  int   runs[$];
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_seg(input bit lvl, input int units);
    for (int k = 0; k < units * U; k++) begin
      exp_env.push_back(lvl);
      exp_tx.push_back(lvl && (((k / CH) % 2) == 0));
    end
  endtask

  // Expected envelope as a list of NEC mark/space segments, expanded to cycles.
  task automatic build_model(input logic [7:0] a, input logic [7:0] c, input bit rep);
    logic [31:0] w;
    exp_env.delete();
    exp_tx.delete();
    w = {~c, c, ~a, a};
    add_seg(1'b1, 16);
    add_seg(1'b0, rep ? 4 : 8);
    if (!rep) begin
      for (int i = 0; i < 32; i++) begin
        add_seg(1'b1, 1);
        add_seg(1'b0, w[i] ? 3 : 1);
      end
    end
    add_seg(1'b1, 1);
  endtask

  task automatic decode(output int lead_mark, output int lead_space, output logic [31:0] word);
    int len;
    runs.delete();
    len = 1;
    for (int i = 1; i < act_env.size(); i++) begin
      if (act_env[i] == act_env[i-1]) len++;
      else begin
        runs.push_back(len);
        len = 1;
      end
    end
    runs.push_back(len);
    lead_mark  = (runs.size() > 0) ? runs[0] : 0;
    lead_space = (runs.size() > 1) ? runs[1] : 0;
    word = '0;
    for (int i = 0; i < 32; i++)
      if (3 + 2 * i < runs.size()) word[i] = (runs[3 + 2 * i] > 2 * U);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] c,
                           input bit rep, input int pulse_at, input bit hold,
                           input int exp_busy, input logic [31:0] exp_word, input int exp_space);
    int L, env_bad, tx_bad, done_bad, busy_len, tx_leak, lm, ls, n, cyc;
    logic [31:0] w;
    build_model(a, c, rep);
    L = exp_env.size();
    act_env.delete();
    env_bad = 0; tx_bad = 0; done_bad = 0; busy_len = 0; tx_leak = 0;
    @(negedge clk);
    bus.iADDR = a; bus.iCMD = c; bus.iREPEAT = rep; bus.iSTART = 1'b1;
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.iADDR = 8'($urandom);
        bus.iCMD  = 8'($urandom);
      end
      bus.iSTART = hold || (k == pulse_at);
      if (bus.oENV !== exp_env[k]) env_bad++;
      if (bus.oIRDA_TX !== exp_tx[k]) tx_bad++;
      if (bus.oDONE !== 1'b0) done_bad++;
      if (bus.oBUSY === 1'b1) busy_len++;
      if (bus.oENV !== 1'b1 && bus.oIRDA_TX !== 1'b0) tx_leak++;
      act_env.push_back(bus.oENV === 1'b1);
    end
    check({tag, "_env_mismatch_cycles"}, 64'(env_bad), 64'd0);
    check({tag, "_carrier_mismatch_cycles"}, 64'(tx_bad), 64'd0);
    check({tag, "_tx_in_space_cycles"}, 64'(tx_leak), 64'd0);
    check({tag, "_early_done_cycles"}, 64'(done_bad), 64'd0);
    check({tag, "_busy_cycles"}, 64'(busy_len), 64'(exp_busy));
    @(negedge clk);
    bus.iSTART = hold;
    check({tag, "_end_done_busy_env_tx"},
          64'({bus.oDONE, bus.oBUSY, bus.oENV, bus.oIRDA_TX}), 64'b1000);
    @(negedge clk);
    if (hold) begin
      check({tag, "_b2b_busy"}, 64'(bus.oBUSY), 64'd1);
      bus.iSTART = 1'b0;
      n = 0;
      cyc = 0;
      while (bus.oDONE !== 1'b1 && cyc < 5000) begin
        if (bus.oBUSY === 1'b1) n++;
        cyc++;
        @(negedge clk);
      end
      check({tag, "_b2b_len"}, 64'(n), 64'(L));
      @(negedge clk);
    end else begin
      check({tag, "_post_done_busy"}, 64'({bus.oDONE, bus.oBUSY}), 64'd0);
    end
    decode(lm, ls, w);
    check({tag, "_lead_mark"}, 64'(lm), 64'(16 * U));
    check({tag, "_lead_space"}, 64'(ls), 64'(exp_space));
    if (!rep) check({tag, "_decoded_word"}, 64'(w), 64'(exp_word));
  endtask

  initial begin
    logic [7:0]  ra, rc;
    bit          rr;
    int          done_seen, busy_seen;

    tbl[0] = '{8'h00, 8'h1A, 1'b0,  -1, 1'b0, 1210, 32'hE51AFF00, 80};
    tbl[1] = '{8'h00, 8'h00, 1'b1,  -1, 1'b0,  210, 32'h00000000, 40};
    tbl[2] = '{8'h5A, 8'h3C, 1'b0, 500, 1'b0, 1210, 32'hC33CA55A, 80};
    tbl[3] = '{8'hFF, 8'h00, 1'b1,  -1, 1'b1,  210, 32'h00000000, 40};
    tbl[4] = '{8'hFF, 8'h00, 1'b0,  -1, 1'b0, 1210, 32'hFF0000FF, 80};

    bus.iSTART = 1'b0; bus.iREPEAT = 1'b0; bus.iADDR = '0; bus.iCMD = '0;
    #1;
    check("reset_outputs", 64'({bus.oIRDA_TX, bus.oENV, bus.oBUSY, bus.oDONE}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'({bus.oIRDA_TX, bus.oENV, bus.oBUSY, bus.oDONE}), 64'd0);

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].addr, tbl[i].cmd, tbl[i].rep, tbl[i].pulse_at,
                tbl[i].hold, tbl[i].exp_busy, tbl[i].exp_word, tbl[i].exp_space);

    // Abort in the first bit space: reset must clear outputs without a clock edge.
    @(negedge clk);
    bus.iADDR = 8'h00; bus.iCMD = 8'h1A; bus.iREPEAT = 1'b0; bus.iSTART = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
    repeat (254) @(negedge clk);
    check("abort_pre_state", 64'({bus.oBUSY, bus.oENV}), 64'b10);
    #2 rst_n = 1'b0;
    #1 check("abort_async_clear", 64'({bus.oIRDA_TX, bus.oENV, bus.oBUSY, bus.oDONE}), 64'd0);
    done_seen = 0;
    busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.oDONE !== 1'b0) done_seen++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.oDONE !== 1'b0) done_seen++;
      if (bus.oBUSY !== 1'b0) busy_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_stays_idle", 64'(busy_seen), 64'd0);
    run_frame("after_abort", 8'h00, 8'h1A, 1'b0, -1, 1'b0, 1210, 32'hE51AFF00, 80);

    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom);
      rc = 8'($urandom);
      rr = ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rand%0d", i), ra, rc, rr, -1, 1'b0, rr ? 210 : 1210,
                {~rc, rc, ~ra, ra}, rr ? 40 : 80);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_transmit.md
# ir_transmit

NEC-protocol infrared transmitter, the sending end of the link decoded by `IR_RECEIVE`. It accepts an 8-bit address and an 8-bit command and emits a full NEC frame: leader, address, ~address, command, ~command (LSB first), then a stop mark. It can also emit an NEC repeat code. The output is a 38 kHz-modulated mark/space waveform for an IR LED driver, plus a bare envelope for looping back into `IR_RECEIVE.iIRDA` on the board.

## Interface
Parameters:
- `UNIT_CYCLES`, default 28125: clocks per 562.5 µs NEC time unit at 50 MHz.
- `CARRIER_HALF`, default 658: clocks per carrier half-period, giving ≈38 kHz.

Ports:
- `iCLK` in 1: 50 MHz clock (`CLOCK_50`).
- `iRST_n` in 1: asynchronous active-low reset.
- `iSTART` in 1: request transmission; sampled only in IDLE.
- `iREPEAT` in 1: sampled with `iSTART`. 1 sends a repeat code; 0 sends a full frame.
- `iADDR` in 8: address byte, latched on accepted start.
- `iCMD` in 8: command byte, latched on accepted start.
- `oIRDA_TX` in/out: out 1. Modulated output, equal to `oENV` AND the carrier phase.
- `oENV` out 1: envelope; 1 during a mark, 0 during a space.
- `oBUSY` out 1: high from the cycle after an accepted start until frame end.
- `oDONE` out 1: one-cycle pulse on frame completion.

## Operation
- Frame word is latched as {~iCMD, iCMD, ~iADDR, iADDR}. Bit 0 is sent first, so `IR_RECEIVE.oDATA[23:16]` equals `iCMD`.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
- Full frame sequence, durations in units:
  - LEAD_MARK 16
  - LEAD_SPACE 8
  - 32 × (BIT_MARK 1, then BIT_SPACE of 1 for a '0' or 3 for a '1')
  - STOP_MARK 1
  - IDLE
- Repeat sequence: LEAD_MARK 16 → REP_SPACE 4 → STOP_MARK 1 → IDLE.
- Counters:
  - Unit counter counts `UNIT_CYCLES`-1 down to 0; one unit ends at 0.
  - Segment counter holds the remaining units of the current state.
  - 5-bit bit index advances after each BIT_SPACE; leave BIT_SPACE for STOP_MARK when the index reaches 31.
- Carrier: phase register toggles every `CARRIER_HALF` clocks. Phase and counter are forced to phase=1, count=0 at the first cycle of every mark state, so each mark starts with the carrier high.
- `iSTART` while `oBUSY` is ignored. Input bytes may change freely after acceptance.
- If `iSTART` is held high continuously, a new frame starts on the first IDLE cycle after `oDONE`.

## Timing
- Reset (async, immediate) values:
  - `oIRDA_TX`=0, `oENV`=0, `oBUSY`=0, `oDONE`=0.
  - State=IDLE, all counters 0.
  - Reset mid-frame aborts with no `oDONE`.
- Accepted start on cycle N, i.e. IDLE and `iSTART`=1 at edge N:
  - `oBUSY`=1 and `oENV`=1 from cycle N+1.
  - LEAD_MARK begins at cycle N+1.
- Frame lengths, all outputs registered:
  - Full frame: 121 units total (16+8+48+48+1). At defaults this is 3 403 125 cycles of `oBUSY`.
  - Repeat code: 21 units = 590 625 cycles.
- After the last STOP_MARK cycle:
  - Next cycle: `oDONE`=1, `oBUSY`=0, `oENV`=0, state IDLE.
  - A new `iSTART` is accepted on that same `oDONE` cycle, giving a back-to-back frame with zero idle cycles.
- `oIRDA_TX` is 0 whenever `oENV`=0. There are no glitches; it is driven from a register.

## Structure
- Shared package `ir_nec_pkg` holds:
  - state enum
  - unit counts: LEAD_MARK_U=16, LEAD_SPACE_U=8, REP_SPACE_U=4, BIT_MARK_U=1, ZERO_SPACE_U=1, ONE_SPACE_U=3, STOP_U=1
  - FRAME_BITS=32
- Sub-module `ir_carrier_gen`: the carrier counter and phase, with a synchronous `restart` input and an `en` input. It is reusable for other IR formats.

## Test plan
Sim parameters for all scenarios unless noted: `UNIT_CYCLES`=10, `CARRIER_HALF`=2.
- Full frame, `iADDR`=8'h00, `iCMD`=8'h1A:
  - `oBUSY` high exactly 1210 cycles.
  - `oENV` leader is 160 high then 80 low.
  - Decoded bit spaces match 32'hE51AFF00, LSB first.
  - `oDONE` is a single pulse.
- Repeat code (`iREPEAT`=1): `oENV` is 160 high, 40 low, 10 high; `oBUSY` is 210 cycles.
- `iSTART` pulsed at cycle 500 of a frame: no effect on the waveform or on total length.
- Reset asserted mid BIT_SPACE: all outputs 0 asynchronously; no `oDONE`. After release, a new start produces a correct frame.
- Carrier check: during every mark `oIRDA_TX` toggles every 2 cycles starting high; it is 0 throughout every space.
- Loopback at default parameters into `IR_RECEIVE` with `iCMD`=8'h1E: `oDATA_READY` falls and `oDATA[23:16]`=8'h1E.
